// File: rtl/seq_mult_hs_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encodings
// and the default operand width.
package mult_pkg;

   localparam int MULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_mult_hs_if.sv
// Operand/result handshake bundle between a caller (master) and the multiplier (slave).
interface seq_mult_hs_if
   import mult_pkg::*;
   #(parameter int WIDTH = MULT_WIDTH) ();

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 sgn;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;

   modport master (
      output in_valid, a, b, sgn, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, sgn, out_ready,
      output in_ready, out_valid, p, busy
   );

endinterface

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: magnitude capture, (WIDTH+1)-bit accumulate with carry shift-in,
// and sign restoration on the final step. Sequenced by load/step/finish strobes.
module mult_shift_add_dp #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 re_n,
   input  logic                 i_load,
   input  logic                 i_step,
   input  logic                 i_finish,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   input  logic                 i_sgn,
   output logic [2*WIDTH-1:0]   o_p
);

   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_neg;

   logic [WIDTH-1:0]     w_magA;
   logic [WIDTH-1:0]     w_magB;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_accNext;
   logic [2*WIDTH-1:0]   w_product;

   // Magnitudes stay WIDTH-bit unsigned, so the most negative operand maps to 2^(WIDTH-1) exactly
   assign w_magA = (i_sgn & i_a[WIDTH-1]) ? (~i_a) + WIDTH'(1) : i_a;
   assign w_magB = (i_sgn & i_b[WIDTH-1]) ? (~i_b) + WIDTH'(1) : i_b;

   // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits
   assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_accNext = {w_sum, r_acc[WIDTH-1:1]};
   assign w_product = r_neg ? (~w_accNext) + (2*WIDTH)'(1) : w_accNext;

   always_ff @(posedge clk) begin
      if (!re_n) begin
         r_mcand <= '0;
         r_acc   <= '0;
         r_neg   <= 1'b0;
         o_p     <= '0;
      end else begin
         if (i_load) begin
            r_mcand <= w_magA;
            r_acc   <= {{WIDTH{1'b0}}, w_magB};
            r_neg   <= i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         end else if (i_step) begin
            r_acc   <= w_accNext;
         end
         if (i_finish) begin
            o_p <= w_product;
         end
      end
   end

endmodule

// File: rtl/seq_mult_hs.sv
// Sequential multiplier top: IDLE/BUSY/DONE control, bit counter and handshakes around
// the shift-add datapath. Latency is exactly WIDTH cycles for every operand pair.
module seq_mult_hs
   import mult_pkg::*;
   #(parameter int WIDTH = MULT_WIDTH) (
   input  logic           clk,
   input  logic           re_n,
   seq_mult_hs_if.slave   bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t          r_state;
   state_t          w_nextState;
   logic [CW-1:0]   r_cnt;
   logic            w_load;
   logic            w_step;
   logic            w_finish;
   logic            w_lastBit;

   assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!re_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (!re_n) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= '0;
      end else if (w_step) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // The last BUSY cycle both steps and latches the result, so no extra cycle is spent
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_load      = 1'b1;
               w_nextState = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_step = 1'b1;
            if (w_lastBit) begin
               w_finish    = 1'b1;
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.busy      = (r_state == ST_BUSY) || (r_state == ST_DONE);

   mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .re_n     (re_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_finish (w_finish),
      .i_a      (bus.a),
      .i_b      (bus.b),
      .i_sgn    (bus.sgn),
      .o_p      (bus.p)
   );

endmodule

// File: tb/tb_seq_mult_hs.sv
// Scoreboard bench for seq_mult_hs: directed operand vectors at WIDTH=16, 4 and 32,
// with expected products queued at issue and popped by per-instance output monitors.
module tb_seq_mult_hs;

   localparam int W = 16;

   logic clk   = 1'b0;
   logic re_n  = 1'b0;
   logic re2_n = 1'b0;

   always #5 clk = ~clk;

   seq_mult_hs_if #(.WIDTH(W))  bus   ();
   seq_mult_hs_if #(.WIDTH(4))  bus4  ();
   seq_mult_hs_if #(.WIDTH(32)) bus32 ();

   seq_mult_hs #(.WIDTH(W))  dut   (.clk(clk), .re_n(re_n),  .bus(bus));
   seq_mult_hs #(.WIDTH(4))  dut4  (.clk(clk), .re_n(re2_n), .bus(bus4));
   seq_mult_hs #(.WIDTH(32)) dut32 (.clk(clk), .re_n(re2_n), .bus(bus32));

   int nCompared   = 0;
   int nMismatched = 0;
   logic [63:0] expQ[$];
   logic [63:0] expQ4[$];
   logic [63:0] expQ32[$];
   bit done4  = 1'b0;
   bit done32 = 1'b0;

   localparam logic [3:0]  A4 [6]  = '{4'hF, 4'h8, 4'h8, 4'h7, 4'h0, 4'h9};
   localparam logic [3:0]  B4 [6]  = '{4'hF, 4'h8, 4'h7, 4'hF, 4'h9, 4'h9};
   localparam logic        S4 [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [7:0]  P4 [6]  = '{8'hE1, 8'h40, 8'hC8, 8'hF9, 8'h00, 8'h51};

   localparam logic [31:0] A32 [4] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
   localparam logic [31:0] B32 [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000005, 32'h00000010};
   localparam logic        S32 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic [63:0] P32 [4] = '{64'hFFFFFFFE00000001, 64'h4000000000000000,
                                       64'hFFFFFFFFFFFFFFFB, 64'h0000000123456780};

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic noteUnexpected(input string name, input logic [63:0] actual);
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: output %0h presented with nothing expected", name, actual);
   endtask

   // Waits for IDLE, presents one operation, queues its product when push is set
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s,
                                input logic [31:0] expP, input bit push);
      int waitCnt = 0;
      @(posedge clk); #1;
      while (!bus.in_ready && waitCnt < 200) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!bus.in_ready) begin
         checkOutput("acceptTimeout16", 64'(bus.in_ready), 64'd1);
         return;
      end
      bus.a        = a;
      bus.b        = b;
      bus.sgn      = s;
      bus.in_valid = 1'b1;
      if (push) expQ.push_back(64'(expP));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int waitCnt = 0;
      while (!bus.in_ready && waitCnt < 200) begin
         @(posedge clk); #1;
         waitCnt++;
      end
   endtask

   always @(negedge clk) begin
      if (re_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (expQ.size() == 0) noteUnexpected("p16", 64'(bus.p));
         else checkOutput("p16", 64'(bus.p), expQ.pop_front());
      end
   end

   always @(negedge clk) begin
      if (re2_n && bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) begin
         if (expQ4.size() == 0) noteUnexpected("p4", 64'(bus4.p));
         else checkOutput("p4", 64'(bus4.p), expQ4.pop_front());
      end
   end

   always @(negedge clk) begin
      if (re2_n && bus32.out_valid === 1'b1 && bus32.out_ready === 1'b1) begin
         if (expQ32.size() == 0) noteUnexpected("p32", 64'(bus32.p));
         else checkOutput("p32", 64'(bus32.p), expQ32.pop_front());
      end
   end

   // WIDTH=4 instance: back-to-back directed vectors with the consumer always ready
   initial begin
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sgn = 1'b0; bus4.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         int waitCnt = 0;
         @(posedge clk); #1;
         while (!bus4.in_ready && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
         end
         if (!bus4.in_ready) begin
            checkOutput("acceptTimeout4", 64'(bus4.in_ready), 64'd1);
            break;
         end
         bus4.a = A4[i]; bus4.b = B4[i]; bus4.sgn = S4[i]; bus4.in_valid = 1'b1;
         expQ4.push_back(64'(P4[i]));
         @(posedge clk); #1;
         bus4.in_valid = 1'b0;
      end
      done4 = 1'b1;
   end

   initial begin
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sgn = 1'b0; bus32.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         int waitCnt = 0;
         @(posedge clk); #1;
         while (!bus32.in_ready && waitCnt < 200) begin
            @(posedge clk); #1;
            waitCnt++;
         end
         if (!bus32.in_ready) begin
            checkOutput("acceptTimeout32", 64'(bus32.in_ready), 64'd1);
            break;
         end
         bus32.a = A32[i]; bus32.b = B32[i]; bus32.sgn = S32[i]; bus32.in_valid = 1'b1;
         expQ32.push_back(P32[i]);
         @(posedge clk); #1;
         bus32.in_valid = 1'b0;
      end
      done32 = 1'b1;
   end

   initial begin
      int latency;
      int badReady;
      int badBusy;
      int bad;
      int waitCnt;

      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sgn = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      checkOutput("rstInReady",  64'(bus.in_ready),  64'd1);
      checkOutput("rstOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("rstBusy",     64'(bus.busy),      64'd0);
      checkOutput("rstP",        64'(bus.p),         64'd0);
      re_n  = 1'b1;
      re2_n = 1'b1;

      // Exact latency and in_ready/busy behaviour while an operation is in flight
      applyStimulus(16'd3, 16'd5, 1'b0, 32'h0000000F, 1'b1);
      latency = 0; badReady = 0; badBusy = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            latency = i;
            break;
         end
         if (bus.in_ready) badReady++;
         if (!bus.busy) badBusy++;
      end
      checkOutput("latency",    64'(latency),  64'd16);
      checkOutput("inReadyLow", 64'(badReady), 64'd0);
      checkOutput("busyHigh",   64'(badBusy),  64'd0);

      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
      applyStimulus(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b1);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b1);
      applyStimulus(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
      applyStimulus(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 1'b1);
      applyStimulus(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b1);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 1'b1);
      applyStimulus(16'hFFFE, 16'hFFFD, 1'b1, 32'h00000006, 1'b1);
      applyStimulus(16'h0000, 16'h1234, 1'b0, 32'h00000000, 1'b1);

      // Backpressure: result held while the consumer stalls, new operands ignored
      waitIdle();
      bus.out_ready = 1'b0;
      applyStimulus(16'h1234, 16'h0010, 1'b0, 32'h00012340, 1'b1);
      waitCnt = 0;
      while (!bus.out_valid && waitCnt < 40) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checkOutput("bpValid", 64'(bus.out_valid), 64'd1);
      checkOutput("bpP",     64'(bus.p),         64'h0000000000012340);
      bad = 0;
      bus.a = 16'd7; bus.b = 16'd9; bus.sgn = 1'b0; bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!bus.out_valid || bus.p !== 32'h00012340 || bus.in_ready) bad++;
      end
      checkOutput("bpStable", 64'(bad), 64'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("relOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("relInReady",  64'(bus.in_ready),  64'd1);
      checkOutput("relBusy",     64'(bus.busy),      64'd0);

      // Reset part-way through BUSY aborts the operation without producing a result
      applyStimulus(16'd100, 16'd100, 1'b0, 32'd0, 1'b0);
      repeat (7) begin
         @(posedge clk); #1;
      end
      re_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("abortInReady",  64'(bus.in_ready),  64'd1);
      checkOutput("abortOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("abortBusy",     64'(bus.busy),      64'd0);
      checkOutput("abortP",        64'(bus.p),         64'd0);
      re_n = 1'b1;
      applyStimulus(16'd2, 16'd7, 1'b0, 32'd14, 1'b1);

      waitCnt = 0;
      while (!(done4 && done32) && waitCnt < 2000) begin
         @(posedge clk);
         waitCnt++;
      end
      checkOutput("auxDone", 64'(done4 && done32), 64'd1);
      repeat (60) @(posedge clk);
      @(negedge clk);
      checkOutput("drain16", 64'(expQ.size()),   64'd0);
      checkOutput("drain4",  64'(expQ4.size()),  64'd0);
      checkOutput("drain32", 64'(expQ32.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
